load_store_unit: RTL and testbench

//  Initiator side of the DataMemory interface: takes byte-addressed load/store requests from the datapath, drives MemoryRead/

---
 rtl/lsu_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 36 +++
 rtl/load_store_unit.sv | 174 +++++++++++++++++
 tb/tb_load_store_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states and lane mask helper.
package lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RWAIT,
    ST_WR,
    ST_RESP
  } lsu_state_e;

  // One bit per byte lane touched by an access of the given size at the given offset.
  function automatic logic [7:0] byte_mask(input logic [1:0] size, input logic [2:0] offset);
    logic [7:0] base;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << offset;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane handling: load extract with sign/zero extension, and store merge into a fetched word.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [2:0]  offset,
  input  logic        is_signed,
  input  logic [63:0] rdata,
  input  logic [63:0] wdata,
  output logic [63:0] load_data,
  output logic [63:0] merged
);

  logic [7:0]  bmask;
  logic [63:0] bit_mask;
  logic [63:0] shifted;
  logic [63:0] wshift;

  always_comb begin
    bmask    = byte_mask(size, offset);
    bit_mask = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{bmask[i]}};
    end
    shifted = rdata >> {offset, 3'b000};
    wshift  = wdata << {offset, 3'b000};
    merged  = (rdata & ~bit_mask) | (wshift & bit_mask);
    case (size)
      SZ_B:    load_data = is_signed ? {{56{shifted[7]}},  shifted[7:0]}  : {56'd0, shifted[7:0]};
      SZ_H:    load_data = is_signed ? {{48{shifted[15]}}, shifted[15:0]} : {48'd0, shifted[15:0]};
      SZ_W:    load_data = is_signed ? {{32{shifted[31]}}, shifted[31:0]} : {32'd0, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// DataMemory initiator: latches one request, sequences read / read-modify-write / write, returns aligned results.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 64,
  parameter int unsigned RD_LAT    = 1
) (
  input  logic        Clock,
  input  logic        ResetL,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [1:0]  ReqSize,
  input  logic        ReqSigned,
  input  logic [63:0] ReqAddr,
  input  logic [63:0] ReqWData,
  output logic        RespValid,
  output logic [63:0] RespData,
  output logic        RespError,
  output logic [63:0] MemAddress,
  output logic [63:0] MemWriteData,
  output logic        MemoryRead,
  output logic        MemoryWrite,
  input  logic [63:0] MemReadData
);

  lsu_state_e  state_q, state_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [2:0]  off_q, off_d;
  logic [63:0] wdata_q, wdata_d;
  logic [15:0] cnt_q, cnt_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        resp_valid_q, resp_valid_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic        resp_err_q, resp_err_d;

  logic        misaligned, out_of_range;
  logic [63:0] load_data, merged;

  lsu_lane_align u_align (
    .size      (size_q),
    .offset    (off_q),
    .is_signed (signed_q),
    .rdata     (MemReadData),
    .wdata     (wdata_q),
    .load_data (load_data),
    .merged    (merged)
  );

  always_comb begin
    case (ReqSize)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = ReqAddr[0];
      SZ_W:    misaligned = |ReqAddr[1:0];
      default: misaligned = |ReqAddr[2:0];
    endcase
    out_of_range = {3'b000, ReqAddr[63:3]} >= 64'(MEM_WORDS);
  end

  always_comb begin
    state_d     = state_q;
    write_d     = write_q;
    size_d      = size_q;
    signed_d    = signed_q;
    off_d       = off_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (ReqValid) begin
          write_d  = ReqWrite;
          size_d   = ReqSize;
          signed_d = ReqSigned;
          off_d    = ReqAddr[2:0];
          wdata_d  = ReqWData;
          if (misaligned || out_of_range) begin
            state_d     = ST_RESP;
            resp_err_d  = 1'b1;
            resp_data_d = '0;
          end else begin
            mem_addr_d = {3'b000, ReqAddr[63:3]};
            if (ReqWrite && ReqSize == SZ_D) begin
              state_d     = ST_WR;
              mem_wdata_d = ReqWData;
            end else begin
              state_d = ST_RD;
            end
          end
        end
      end
      ST_RD: begin
        state_d = ST_RWAIT;
        cnt_d   = 16'(RD_LAT - 1);
      end
      ST_RWAIT: begin
        if (cnt_q == '0) begin
          if (write_q) begin
            state_d     = ST_WR;
            mem_wdata_d = merged;
          end else begin
            state_d     = ST_RESP;
            resp_data_d = load_data;
            resp_err_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_WR: begin
        state_d     = ST_RESP;
        resp_data_d = '0;
        resp_err_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    // Strobes are decoded from the next state so they are flops aligned with their state.
    mem_rd_d     = (state_d == ST_RD);
    mem_wr_d     = (state_d == ST_WR);
    resp_valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge Clock or negedge ResetL) begin
    if (!ResetL) begin
      state_q      <= ST_IDLE;
      write_q      <= 1'b0;
      size_q       <= SZ_B;
      signed_q     <= 1'b0;
      off_q        <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      write_q      <= write_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign ReqReady     = (state_q == ST_IDLE);
  assign RespValid    = resp_valid_q;
  assign RespData     = resp_data_q;
  assign RespError    = resp_err_q;
  assign MemAddress   = mem_addr_q;
  assign MemWriteData = mem_wdata_q;
  assign MemoryRead   = mem_rd_q;
  assign MemoryWrite  = mem_wr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a behavioural 64-word data memory.
module tb_load_store_unit;

  logic        Clock = 1'b0;
  logic        ResetL = 1'b0;
  logic        ReqValid = 1'b0;
  logic        ReqReady;
  logic        ReqWrite = 1'b0;
  logic [1:0]  ReqSize = 2'd0;
  logic        ReqSigned = 1'b0;
  logic [63:0] ReqAddr = '0;
  logic [63:0] ReqWData = '0;
  logic        RespValid;
  logic [63:0] RespData;
  logic        RespError;
  logic [63:0] MemAddress;
  logic [63:0] MemWriteData;
  logic        MemoryRead;
  logic        MemoryWrite;
  logic [63:0] mem_rdata = '0;

  logic [63:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  load_store_unit #(.MEM_WORDS(64), .RD_LAT(1)) dut (
    .Clock        (Clock),
    .ResetL       (ResetL),
    .ReqValid     (ReqValid),
    .ReqReady     (ReqReady),
    .ReqWrite     (ReqWrite),
    .ReqSize      (ReqSize),
    .ReqSigned    (ReqSigned),
    .ReqAddr      (ReqAddr),
    .ReqWData     (ReqWData),
    .RespValid    (RespValid),
    .RespData     (RespData),
    .RespError    (RespError),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemoryRead   (MemoryRead),
    .MemoryWrite  (MemoryWrite),
    .MemReadData  (mem_rdata)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) if (MemoryRead) mem_rdata <= mem[MemAddress[5:0]];
  always @(negedge Clock) if (MemoryWrite) mem[MemAddress[5:0]] <= MemWriteData;

  int          lat, nrd, nwr;
  logic [63:0] waddr, wdat, rdat;
  logic        rerr;

  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd);
    logic done;
    @(negedge Clock);
    ReqValid = 1'b1; ReqWrite = w; ReqSize = sz; ReqSigned = sg; ReqAddr = a; ReqWData = wd;
    @(posedge Clock);
    #1;
    ReqValid = 1'b0; ReqWrite = ~w; ReqSize = ~sz; ReqSigned = ~sg; ReqAddr = '1; ReqWData = '1;
    lat = 0; nrd = 0; nwr = 0; waddr = 'x; wdat = 'x; rdat = 'x; rerr = 1'bx;
    done = 1'b0;
    for (int n = 1; n <= 20 && !done; n++) begin
      @(negedge Clock);
      if (MemoryRead && MemoryWrite) begin
        errors++;
        $display("FAIL rd_wr_overlap: got both strobes high, want at most one");
      end
      if (MemoryRead) nrd++;
      if (MemoryWrite) begin nwr++; waddr = MemAddress; wdat = MemWriteData; end
      if (RespValid) begin lat = n; rdat = RespData; rerr = RespError; done = 1'b1; end
    end
  endtask

  task automatic test_reset;
    ResetL = 1'b0;
    #3;
    checks++; if (ReqReady !== 1'b1 || RespValid !== 1'b0 || RespData !== 64'd0 || RespError !== 1'b0) begin
      errors++; $display("FAIL reset_state: got rdy=%b rv=%b rd=%h re=%b, want 1 0 0 0", ReqReady, RespValid, RespData, RespError);
    end
    @(negedge Clock); ResetL = 1'b1;
    @(negedge Clock);
    ReqValid = 1'b1; ReqWrite = 1'b0; ReqSize = 2'd3; ReqSigned = 1'b0; ReqAddr = 64'h8;
    @(posedge Clock);
    #1; ReqValid = 1'b0;
    checks++; if (MemoryRead !== 1'b1) begin
      errors++; $display("FAIL reset_mid_rd_pre: got MemoryRead=%b want 1", MemoryRead);
    end
    ResetL = 1'b0;
    #1;
    checks++; if (MemoryRead !== 1'b0 || MemoryWrite !== 1'b0 || RespValid !== 1'b0) begin
      errors++; $display("FAIL reset_mid_rd: got rd=%b wr=%b rv=%b want 0 0 0", MemoryRead, MemoryWrite, RespValid);
    end
    @(negedge Clock); ResetL = 1'b1;
    #1;
    checks++; if (ReqReady !== 1'b1 || RespData !== 64'd0) begin
      errors++; $display("FAIL reset_release: got rdy=%b rd=%h want 1 0", ReqReady, RespData);
    end
    nrd = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge Clock); if (RespValid || MemoryRead) nrd++;
    end
    checks++; if (nrd !== 0) begin
      errors++; $display("FAIL reset_drop: got %0d active cycles want 0", nrd);
    end
  endtask

  task automatic test_dword;
    do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'hDEADBEEFCAFEF00D);
    checks++; if (lat !== 2 || nwr !== 1 || nrd !== 0) begin
      errors++; $display("FAIL dword_store_timing: got lat=%0d wr=%0d rd=%0d want 2 1 0", lat, nwr, nrd);
    end
    checks++; if (waddr !== 64'd2 || wdat !== 64'hDEADBEEFCAFEF00D) begin
      errors++; $display("FAIL dword_store_data: got addr=%h data=%h want 2 deadbeefcafef00d", waddr, wdat);
    end
    checks++; if (rdat !== 64'd0 || rerr !== 1'b0) begin
      errors++; $display("FAIL dword_store_resp: got data=%h err=%b want 0 0", rdat, rerr);
    end
    do_req(1'b0, 2'd3, 1'b1, 64'h10, 64'h0);
    checks++; if (lat !== 3 || nrd !== 1 || nwr !== 0 || rdat !== 64'hDEADBEEFCAFEF00D) begin
      errors++; $display("FAIL dword_load: got lat=%0d rd=%0d wr=%0d data=%h want 3 1 0 deadbeefcafef00d", lat, nrd, nwr, rdat);
    end
  endtask

  task automatic test_subword;
    do_req(1'b1, 2'd3, 1'b0, 64'h10, 64'h0);
    do_req(1'b1, 2'd0, 1'b0, 64'h13, 64'h80);
    checks++; if (lat !== 4 || nrd !== 1 || nwr !== 1 || waddr !== 64'd2) begin
      errors++; $display("FAIL byte_store_timing: got lat=%0d rd=%0d wr=%0d addr=%h want 4 1 1 2", lat, nrd, nwr, waddr);
    end
    checks++; if (wdat !== 64'h0000000080000000) begin
      errors++; $display("FAIL byte_store_merge: got %h want 0000000080000000", wdat);
    end
    do_req(1'b0, 2'd0, 1'b1, 64'h13, 64'h0);
    checks++; if (rdat !== 64'hFFFFFFFFFFFFFF80 || lat !== 3) begin
      errors++; $display("FAIL byte_load_signed: got %h lat=%0d want ffffffffffffff80 3", rdat, lat);
    end
    do_req(1'b0, 2'd0, 1'b0, 64'h13, 64'h0);
    checks++; if (rdat !== 64'h80) begin
      errors++; $display("FAIL byte_load_unsigned: got %h want 80", rdat);
    end
    do_req(1'b1, 2'd3, 1'b0, 64'h18, 64'h1122334455667788);
    do_req(1'b1, 2'd1, 1'b0, 64'h1C, 64'hFFFF_FFFF_FFFF_ABCD);
    checks++; if (wdat !== 64'h1122ABCD55667788) begin
      errors++; $display("FAIL half_store_merge: got %h want 1122abcd55667788", wdat);
    end
    do_req(1'b0, 2'd2, 1'b1, 64'h1C, 64'h0);
    checks++; if (rdat !== 64'h000000001122ABCD) begin
      errors++; $display("FAIL word_load_signed_pos: got %h want 000000001122abcd", rdat);
    end
    do_req(1'b0, 2'd1, 1'b1, 64'h1C, 64'h0);
    checks++; if (rdat !== 64'hFFFFFFFFFFFFABCD) begin
      errors++; $display("FAIL half_load_signed_neg: got %h want ffffffffffffabcd", rdat);
    end
    do_req(1'b0, 2'd2, 1'b0, 64'h18, 64'h0);
    checks++; if (rdat !== 64'h0000000055667788) begin
      errors++; $display("FAIL word_load_low: got %h want 0000000055667788", rdat);
    end
  endtask

  task automatic test_errors;
    do_req(1'b0, 2'd1, 1'b0, 64'h11, 64'h0);
    checks++; if (lat !== 1 || rerr !== 1'b1 || rdat !== 64'd0 || nrd !== 0 || nwr !== 0) begin
      errors++; $display("FAIL misaligned_half: got lat=%0d err=%b data=%h rd=%0d wr=%0d want 1 1 0 0 0", lat, rerr, rdat, nrd, nwr);
    end
    do_req(1'b0, 2'd3, 1'b0, 64'h200, 64'h0);
    checks++; if (lat !== 1 || rerr !== 1'b1 || nrd !== 0 || nwr !== 0) begin
      errors++; $display("FAIL range_word64: got lat=%0d err=%b rd=%0d wr=%0d want 1 1 0 0", lat, rerr, nrd, nwr);
    end
    do_req(1'b0, 2'd2, 1'b0, 64'h7FC, 64'h0);
    checks++; if (lat !== 1 || rerr !== 1'b1 || nrd !== 0) begin
      errors++; $display("FAIL range_word255: got lat=%0d err=%b rd=%0d want 1 1 0", lat, rerr, nrd);
    end
    do_req(1'b1, 2'd3, 1'b0, 64'h1C, 64'h0);
    checks++; if (rerr !== 1'b1 || nwr !== 0 || mem[3] !== 64'h1122ABCD55667788) begin
      errors++; $display("FAIL misaligned_store: got err=%b wr=%0d word3=%h want 1 0 1122abcd55667788", rerr, nwr, mem[3]);
    end
    do_req(1'b0, 2'd3, 1'b0, 64'h1F8, 64'h0);
    checks++; if (rerr !== 1'b0 || lat !== 3) begin
      errors++; $display("FAIL range_last_word: got err=%b lat=%0d want 0 3", rerr, lat);
    end
  endtask

  task automatic test_hold;
    do_req(1'b0, 2'd3, 1'b0, 64'h10, 64'h0);
    repeat (3) @(negedge Clock);
    checks++; if (RespValid !== 1'b0 || RespData !== 64'h0000000080000000 || ReqReady !== 1'b1) begin
      errors++; $display("FAIL resp_hold: got rv=%b data=%h rdy=%b want 0 0000000080000000 1", RespValid, RespData, ReqReady);
    end
  endtask

  task automatic test_reset_during_write;
    do_req(1'b1, 2'd3, 1'b0, 64'h28, 64'h0123456789ABCDEF);
    @(negedge Clock);
    ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'd3; ReqAddr = 64'h28; ReqWData = '1;
    @(posedge Clock);
    #1; ReqValid = 1'b0;
    checks++; if (MemoryWrite !== 1'b1) begin
      errors++; $display("FAIL abort_wr_pre: got MemoryWrite=%b want 1", MemoryWrite);
    end
    ResetL = 1'b0;
    #1;
    checks++; if (MemoryWrite !== 1'b0 || RespValid !== 1'b0) begin
      errors++; $display("FAIL abort_wr_strobe: got wr=%b rv=%b want 0 0", MemoryWrite, RespValid);
    end
    nrd = 0;
    repeat (2) begin @(negedge Clock); if (RespValid) nrd++; end
    ResetL = 1'b1;
    repeat (3) begin @(negedge Clock); if (RespValid) nrd++; end
    checks++; if (nrd !== 0) begin
      errors++; $display("FAIL abort_no_resp: got %0d RespValid cycles want 0", nrd);
    end
    do_req(1'b0, 2'd3, 1'b0, 64'h28, 64'h0);
    checks++; if (rdat !== 64'h0123456789ABCDEF) begin
      errors++; $display("FAIL abort_word_kept: got %h want 0123456789abcdef", rdat);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    test_reset();
    test_dword();
    test_subword();
    test_errors();
    test_hold();
    test_reset_during_write();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
